// File: rtl/hood_mode_pkg.sv
// Shared encodings for the hood mode scheduler: mode states, fan speeds, countdown width.
// Pure declarations: no latency, no backpressure.
package hood_mode_pkg;

    localparam int CD_W = 8;

    typedef enum logic [2:0] {
        MODE_OFF     = 3'd0,
        MODE_STANDBY = 3'd1,
        MODE_MENU    = 3'd2,
        MODE_LVL1    = 3'd3,
        MODE_LVL2    = 3'd4,
        MODE_LVL3    = 3'd5,
        MODE_RETURN  = 3'd6,
        MODE_CLEAN   = 3'd7
    } mode_e;

    localparam logic [1:0] FAN_OFF  = 2'd0;
    localparam logic [1:0] FAN_LOW  = 2'd1;
    localparam logic [1:0] FAN_MID  = 2'd2;
    localparam logic [1:0] FAN_HIGH = 2'd3;

    function automatic logic is_timed(input mode_e m);
        return (m == MODE_LVL3) || (m == MODE_RETURN) || (m == MODE_CLEAN);
    endfunction

endpackage

// File: rtl/hood_mode_scheduler_sec_tick_gen.sv
// Per-second prescaler: tick is high for one cycle while the count sits at TICKS-1.
// Clear takes effect at the next edge and suppresses the tick; no backpressure.
module sec_tick_gen #(
    parameter int TICKS = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int         W    = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [W-1:0] LAST = W'(TICKS - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/hood_mode_scheduler.sv
// Kitchen-hood mode FSM: standby/menu/fan levels/return/self-clean with per-second countdowns.
// All outputs registered (one cycle after cause); button pulses are never held off.
module hood_mode_scheduler
    import hood_mode_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int HURRICANE_SEC = 60,
    parameter int RETURN_SEC    = 60,
    parameter int CLEAN_SEC     = 180
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            machine_state,
    input  logic            menu_btn,
    input  logic            lvl1_btn,
    input  logic            lvl2_btn,
    input  logic            lvl3_btn,
    input  logic            clean_btn,
    output logic [2:0]      mode,
    output logic [1:0]      fan_level,
    output logic [CD_W-1:0] countdown,
    output logic            hurricane_used,
    output logic            clean_done
);

    localparam logic [CD_W-1:0] HURR_CNT  = CD_W'(HURRICANE_SEC);
    localparam logic [CD_W-1:0] RET_CNT   = CD_W'(RETURN_SEC);
    localparam logic [CD_W-1:0] CLEAN_CNT = CD_W'(CLEAN_SEC);
    localparam logic [CD_W-1:0] CD_ONE    = CD_W'(1);

    mode_e state;
    logic  tick;
    logic  tick_clr;

    // Prescaler restarts on every timed-state entry, including LVL3 -> RETURN.
    assign tick_clr = !machine_state || !is_timed(state) ||
                      (state == MODE_LVL3 && menu_btn);

    sec_tick_gen #(
        .TICKS(TICKS_PER_SEC)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (tick_clr),
        .tick(tick)
    );

    assign mode = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= MODE_OFF;
            fan_level      <= FAN_OFF;
            countdown      <= '0;
            hurricane_used <= 1'b0;
            clean_done     <= 1'b0;
        end else begin
            clean_done <= 1'b0;
            if (!machine_state) begin
                state          <= MODE_OFF;
                fan_level      <= FAN_OFF;
                countdown      <= '0;
                hurricane_used <= 1'b0;
            end else begin
                case (state)
                    MODE_OFF: begin
                        state <= MODE_STANDBY;
                    end
                    MODE_STANDBY: begin
                        if (menu_btn) state <= MODE_MENU;
                    end
                    MODE_MENU: begin
                        if (menu_btn) begin
                            state <= MODE_STANDBY;
                        end else if (lvl3_btn && !hurricane_used) begin
                            state          <= MODE_LVL3;
                            fan_level      <= FAN_HIGH;
                            countdown      <= HURR_CNT;
                            hurricane_used <= 1'b1;
                        end else if (lvl2_btn) begin
                            state     <= MODE_LVL2;
                            fan_level <= FAN_MID;
                        end else if (lvl1_btn) begin
                            state     <= MODE_LVL1;
                            fan_level <= FAN_LOW;
                        end else if (clean_btn) begin
                            state     <= MODE_CLEAN;
                            fan_level <= FAN_OFF;
                            countdown <= CLEAN_CNT;
                        end
                    end
                    MODE_LVL1: begin
                        if (menu_btn) begin
                            state     <= MODE_STANDBY;
                            fan_level <= FAN_OFF;
                        end else if (lvl2_btn) begin
                            state     <= MODE_LVL2;
                            fan_level <= FAN_MID;
                        end
                    end
                    MODE_LVL2: begin
                        if (menu_btn) begin
                            state     <= MODE_STANDBY;
                            fan_level <= FAN_OFF;
                        end else if (lvl1_btn) begin
                            state     <= MODE_LVL1;
                            fan_level <= FAN_LOW;
                        end
                    end
                    MODE_LVL3: begin
                        if (menu_btn) begin
                            state     <= MODE_RETURN;
                            countdown <= RET_CNT;
                        end else if (tick) begin
                            if (countdown == CD_ONE) begin
                                state     <= MODE_LVL2;
                                fan_level <= FAN_MID;
                                countdown <= '0;
                            end else begin
                                countdown <= countdown - 1'b1;
                            end
                        end
                    end
                    MODE_RETURN: begin
                        if (tick) begin
                            if (countdown == CD_ONE) begin
                                state     <= MODE_STANDBY;
                                fan_level <= FAN_OFF;
                                countdown <= '0;
                            end else begin
                                countdown <= countdown - 1'b1;
                            end
                        end
                    end
                    MODE_CLEAN: begin
                        if (tick) begin
                            if (countdown == CD_ONE) begin
                                state      <= MODE_STANDBY;
                                countdown  <= '0;
                                clean_done <= 1'b1;
                            end else begin
                                countdown <= countdown - 1'b1;
                            end
                        end
                    end
                    default: begin
                        state     <= MODE_OFF;
                        fan_level <= FAN_OFF;
                        countdown <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hood_mode_scheduler.sv
// Directed plus random stimulus against a remaining-cycles reference model of the hood scheduler.
module tb_hood_mode_scheduler;

    localparam int TPS = 4;
    localparam int HS  = 3;
    localparam int RS  = 2;
    localparam int CS  = 5;

    localparam int OFF = 0, STANDBY = 1, MENU = 2, LVL1 = 3;
    localparam int LVL2 = 4, LVL3 = 5, RETN = 6, CLEAN = 7;

    // button vector bits: {clean, lvl3, lvl2, lvl1, menu}
    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_MENU = 5'b00001;
    localparam logic [4:0] B_L1   = 5'b00010;
    localparam logic [4:0] B_L2   = 5'b00100;
    localparam logic [4:0] B_L3   = 5'b01000;
    localparam logic [4:0] B_CLN  = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       machine_state = 1'b0;
    logic       menu_btn = 1'b0, lvl1_btn = 1'b0, lvl2_btn = 1'b0;
    logic       lvl3_btn = 1'b0, clean_btn = 1'b0;
    logic [2:0] mode;
    logic [1:0] fan_level;
    logic [7:0] countdown;
    logic       hurricane_used;
    logic       clean_done;

    int errors = 0;
    int checks = 0;

    // reference model: mode, remaining cycles in the timed state, flags
    int m_mode = OFF;
    int m_rem  = 0;
    bit m_hu   = 1'b0;
    bit m_done = 1'b0;

    always #5 clk = ~clk;

    hood_mode_scheduler #(
        .TICKS_PER_SEC(TPS),
        .HURRICANE_SEC(HS),
        .RETURN_SEC   (RS),
        .CLEAN_SEC    (CS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .machine_state (machine_state),
        .menu_btn      (menu_btn),
        .lvl1_btn      (lvl1_btn),
        .lvl2_btn      (lvl2_btn),
        .lvl3_btn      (lvl3_btn),
        .clean_btn     (clean_btn),
        .mode          (mode),
        .fan_level     (fan_level),
        .countdown     (countdown),
        .hurricane_used(hurricane_used),
        .clean_done    (clean_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int fan_of(input int m);
        case (m)
            LVL1:       return 1;
            LVL2:       return 2;
            LVL3, RETN: return 3;
            default:    return 0;
        endcase
    endfunction

    function automatic int exp_cd();
        if (m_mode == LVL3 || m_mode == RETN || m_mode == CLEAN)
            return (m_rem + TPS - 1) / TPS;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = OFF; m_rem = 0; m_hu = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_step(input bit ms, input logic [4:0] b);
        bit mb, l1, l2, l3, cb;
        {cb, l3, l2, l1, mb} = b;
        m_done = 1'b0;
        if (!ms) begin
            m_mode = OFF; m_rem = 0; m_hu = 1'b0;
            return;
        end
        case (m_mode)
            OFF:     m_mode = STANDBY;
            STANDBY: if (mb) m_mode = MENU;
            MENU: begin
                if (mb)                m_mode = STANDBY;
                else if (l3 && !m_hu) begin m_mode = LVL3; m_hu = 1'b1; m_rem = HS * TPS; end
                else if (l2)           m_mode = LVL2;
                else if (l1)           m_mode = LVL1;
                else if (cb)     begin m_mode = CLEAN; m_rem = CS * TPS; end
            end
            LVL1: if (mb) m_mode = STANDBY; else if (l2) m_mode = LVL2;
            LVL2: if (mb) m_mode = STANDBY; else if (l1) m_mode = LVL1;
            LVL3: begin
                if (mb) begin
                    m_mode = RETN; m_rem = RS * TPS;
                end else begin
                    m_rem--;
                    if (m_rem == 0) m_mode = LVL2;
                end
            end
            RETN: begin
                m_rem--;
                if (m_rem == 0) m_mode = STANDBY;
            end
            CLEAN: begin
                m_rem--;
                if (m_rem == 0) begin m_mode = STANDBY; m_done = 1'b1; end
            end
            default: m_mode = OFF;
        endcase
    endtask

    task automatic check_all(input string where);
        chk({where, ".mode"}, mode, m_mode);
        chk({where, ".fan"},  fan_level, fan_of(m_mode));
        chk({where, ".cd"},   countdown, exp_cd());
        chk({where, ".hu"},   hurricane_used, m_hu);
        chk({where, ".done"}, clean_done, m_done);
    endtask

    task automatic step(input logic [4:0] b, input string where);
        {clean_btn, lvl3_btn, lvl2_btn, lvl1_btn, menu_btn} = b;
        @(posedge clk);
        model_step(machine_state, b);
        #1;
        {clean_btn, lvl3_btn, lvl2_btn, lvl1_btn, menu_btn} = B_NONE;
        check_all(where);
    endtask

    initial begin
        int n;
        logic [4:0] b;

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;
        machine_state = 1'b1;

        // 1: level 3 entry, per-second countdown, automatic drop to level 2
        step(B_NONE, "t1_on");
        chk("t1_standby", mode, STANDBY);
        step(B_MENU, "t1_menu");
        step(B_L3, "t1_l3");
        chk("t1_lvl3", mode, LVL3);
        chk("t1_fan3", fan_level, 2'd3);
        chk("t1_cd3", countdown, 8'd3);
        repeat (4) step(B_NONE, "t1_run");
        chk("t1_cd2", countdown, 8'd2);
        n = 4;
        while (mode != 3'(LVL2) && n < 20) begin
            step(B_NONE, "t1_wait");
            n++;
        end
        chk("t1_expiry_cycles", n, 12);
        chk("t1_fan2", fan_level, 2'd2);
        chk("t1_hu", hurricane_used, 1'b1);

        // 2: level 3 locked out after use
        step(B_MENU, "t2_sb");
        chk("t2_standby", mode, STANDBY);
        step(B_MENU, "t2_menu");
        step(B_L3, "t2_l3");
        chk("t2_l3_ignored", mode, MENU);
        step(B_L1, "t2_l1");
        chk("t2_lvl1", mode, LVL1);
        chk("t2_fan1", fan_level, 2'd1);

        // 3: leave level 3 early through RETURN
        machine_state = 1'b0;
        step(B_NONE, "t3_off");
        machine_state = 1'b1;
        step(B_NONE, "t3_on");
        step(B_MENU, "t3_menu");
        step(B_L3, "t3_l3");
        repeat (5) step(B_NONE, "t3_run");
        step(B_MENU, "t3_ret");
        chk("t3_return", mode, RETN);
        chk("t3_cd2", countdown, 8'd2);
        chk("t3_fan3", fan_level, 2'd3);
        n = 0;
        while (mode != 3'(STANDBY) && n < 20) begin
            step(B_NONE, "t3_wait");
            n++;
        end
        chk("t3_return_cycles", n, 8);
        chk("t3_fan0", fan_level, 2'd0);

        // 4: self-clean runs to completion, buttons ignored
        step(B_MENU, "t4_menu");
        step(B_CLN, "t4_cln");
        chk("t4_clean", mode, CLEAN);
        chk("t4_cd5", countdown, 8'd5);
        for (int i = 1; i < 20; i++) begin
            for (int k = 0; k < 5; k++) b[k] = ($urandom_range(0, 2) == 0);
            step(b, "t4_run");
        end
        step(B_NONE, "t4_end");
        chk("t4_standby", mode, STANDBY);
        chk("t4_done_hi", clean_done, 1'b1);
        step(B_NONE, "t4_after");
        chk("t4_done_lo", clean_done, 1'b0);

        // 5: power-down mid-clean clears everything
        step(B_MENU, "t5_menu");
        step(B_CLN, "t5_cln");
        repeat (8) step(B_NONE, "t5_run");
        chk("t5_cd3", countdown, 8'd3);
        machine_state = 1'b0;
        step(B_MENU | B_CLN, "t5_off");
        chk("t5_off_mode", mode, OFF);
        chk("t5_off_cd", countdown, 8'd0);
        chk("t5_off_done", clean_done, 1'b0);
        machine_state = 1'b1;
        step(B_NONE, "t5_on");
        step(B_MENU, "t5_menu2");
        step(B_L3, "t5_l3");
        chk("t5_lvl3_again", mode, LVL3);

        // 6: async reset mid-LVL3, then simultaneous lvl2+lvl1 in MENU
        step(B_NONE, "t6_run");
        step(B_NONE, "t6_run");
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_mode", mode, OFF);
        chk("t6_rst_fan", fan_level, 2'd0);
        chk("t6_rst_cd", countdown, 8'd0);
        chk("t6_rst_hu", hurricane_used, 1'b0);
        chk("t6_rst_done", clean_done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_all("t6_held");
        step(B_NONE, "t6_on");
        step(B_MENU, "t6_menu");
        step(B_L2 | B_L1, "t6_l2l1");
        chk("t6_lvl2", mode, LVL2);
        chk("t6_fan2", fan_level, 2'd2);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            machine_state = ($urandom_range(0, 59) != 0);
            for (int k = 0; k < 5; k++) b[k] = ($urandom_range(0, 7) == 0);
            step(b, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
